sensors_intf_nios2_qsys_0_oci_dct_capture: RTL and testbench

Parametrised capture stage for the Nios II OCI debug-compression-trace (DCT) stream in the sensor interface SoC. Accepts packed trace words (`dct_buffer` plus valid-field count `dct_count`), screens them, buffers them in a show-ahead FIFO, and presents them on a valid/ready read port. It also keeps frame, field and drop statistics and drains to a clean end-of-test state on `test_ending` / `test_has_ended`. It sits between the OCI trace packer and the JTAG/trace readout logic.

---
 rtl/sensors_intf_nios2_qsys_0_oci_dct_capture.sv | 86 ++++++++
 tb/tb_sensors_intf_nios2_qsys_0_oci_dct_capture.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sensors_intf_nios2_qsys_0_oci_dct_capture.sv
// sensors_intf_nios2_qsys_0_oci_dct_capture: screens DCT trace words into a show-ahead FIFO with stats and end-of-test drain
module sensors_intf_nios2_qsys_0_oci_dct_capture #(
  parameter int FIELD_W = 2,
  parameter int FIELDS = 15,
  parameter int COUNT_W = 4,
  parameter int DEPTH = 16,
  parameter int CNT_W = 32,
  localparam int BUF_W = FIELD_W * FIELDS,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     dct_valid,
  input  logic [BUF_W-1:0]         dct_buffer,
  input  logic [COUNT_W-1:0]       dct_count,
  input  logic                     test_ending,
  input  logic                     test_has_ended,
  output logic                     rd_valid,
  output logic [BUF_W+COUNT_W-1:0] rd_data,
  input  logic                     rd_ready,
  output logic [AW:0]              fill_level,
  output logic [CNT_W-1:0]         frame_count,
  output logic [CNT_W-1:0]         field_total,
  output logic [CNT_W-1:0]         drop_count,
  output logic                     overflow,
  output logic                     count_err,
  output logic [1:0]               state,
  output logic                     test_done
);
  typedef enum logic [1:0] {RUN = 2'd0, DRAIN = 2'd1, DONE = 2'd2} state_t;
  localparam logic [COUNT_W-1:0] MAX_CNT = COUNT_W'(FIELDS);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  state_t st, st_next;
  logic [BUF_W+COUNT_W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic screen, pop, full, accept, drop, ovf;
  assign rd_valid = fill_level != '0;
  assign rd_data = mem[rd_ptr];
  assign state = st;
  assign full = fill_level == FULL_LVL;
  assign pop = rd_valid && rd_ready;
  assign screen = dct_valid && dct_count != '0 && dct_count <= MAX_CNT;
  assign accept = screen && st == RUN && (!full || pop);
  assign ovf = screen && st == RUN && full && !pop;
  assign drop = screen && (st != RUN || (full && !pop));
  always_comb begin
    st_next = test_has_ended ? DONE :
              (st == RUN && test_ending) ? DRAIN :
              (st == DRAIN && (fill_level == '0 || (fill_level == (AW+1)'(1) && pop))) ? DONE : st;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill_level <= '0;
      frame_count <= '0;
      field_total <= '0;
      drop_count <= '0;
      overflow <= 1'b0;
      count_err <= 1'b0;
      st <= RUN;
      test_done <= 1'b0;
    end else begin
      st <= st_next;
      test_done <= st_next == DONE;
      if (accept) mem[wr_ptr] <= {dct_count, dct_buffer};
      if (test_has_ended) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        fill_level <= '0;
      end else begin
        wr_ptr <= wr_ptr + AW'(accept);
        rd_ptr <= rd_ptr + AW'(pop);
        fill_level <= fill_level + (AW+1)'(accept) - (AW+1)'(pop);
      end
      if (accept) begin
        frame_count <= frame_count + CNT_W'(1);
        field_total <= field_total + CNT_W'(dct_count);
      end
      if (drop && ~&drop_count) drop_count <= drop_count + CNT_W'(1);
      overflow <= overflow | ovf;
      count_err <= count_err | (dct_valid && dct_count > MAX_CNT);
    end
  end
endmodule

// File: tb/tb_sensors_intf_nios2_qsys_0_oci_dct_capture.sv
// tb_sensors_intf_nios2_qsys_0_oci_dct_capture: directed checks of the DCT capture FIFO, screening and end-of-test flow
module tb_sensors_intf_nios2_qsys_0_oci_dct_capture;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic dct_valid = 1'b0;
  logic [29:0] dct_buffer = '0;
  logic [3:0] dct_count = '0;
  logic test_ending = 1'b0;
  logic test_has_ended = 1'b0;
  logic rd_ready = 1'b0;
  logic rd_valid, overflow, count_err, test_done;
  logic [33:0] rd_data;
  logic [4:0] fill_level;
  logic [31:0] frame_count, field_total, drop_count;
  logic [1:0] state;
  logic v14 = 1'b0;
  logic [27:0] b14 = '0;
  logic [3:0] c14 = '0;
  logic rv14, ovf14, cerr14, done14;
  logic [31:0] rdd14;
  logic [4:0] fill14;
  logic [31:0] frm14, fld14, drp14;
  logic [1:0] st14;
  int n_checks = 0;
  int n_fail = 0;
  logic [33:0] exp_q [$];

  always #5 clk = ~clk;

  sensors_intf_nios2_qsys_0_oci_dct_capture dut (
    .clk(clk), .reset_n(reset_n), .dct_valid(dct_valid), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready), .fill_level(fill_level),
    .frame_count(frame_count), .field_total(field_total), .drop_count(drop_count),
    .overflow(overflow), .count_err(count_err), .state(state), .test_done(test_done)
  );

  sensors_intf_nios2_qsys_0_oci_dct_capture #(.FIELDS(14)) u14 (
    .clk(clk), .reset_n(reset_n), .dct_valid(v14), .dct_buffer(b14),
    .dct_count(c14), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .rd_valid(rv14), .rd_data(rdd14), .rd_ready(rd_ready), .fill_level(fill14),
    .frame_count(frm14), .field_total(fld14), .drop_count(drp14),
    .overflow(ovf14), .count_err(cerr14), .state(st14), .test_done(done14)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [33:0] w);
    dct_valid = 1'b1;
    {dct_count, dct_buffer} = w;
    step();
    dct_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  function automatic logic [33:0] wd(input int k);
    logic [29:0] b;
    logic [3:0] c;
    b = 30'(k * 32'h0111_1111 + 7);
    c = 4'((k % 15) + 1);
    return {c, b};
  endfunction

  initial begin
    #12;
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_fill", fill_level, 0);
    check("rst_frame", frame_count, 0);
    check("rst_state", state, 0);
    check("rst_test_done", test_done, 0);
    step();
    reset_n = 1'b1;
    // basic flow
    rd_ready = 1'b1;
    push({4'hF, 30'h2AAAAAAA});
    check("basic_rd_valid", rd_valid, 1);
    check("basic_rd_data", rd_data, {30'd0, 4'hF, 30'h2AAAAAAA});
    check("basic_frame", frame_count, 1);
    check("basic_field", field_total, 15);
    step();
    check("basic_drained", fill_level, 0);
    // count 0 is silently discarded
    push({4'h0, 30'h1234});
    check("cnt0_frame", frame_count, 1);
    check("cnt0_field", field_total, 15);
    check("cnt0_drop", drop_count, 0);
    check("cnt0_err", count_err, 0);
    check("cnt0_fill", fill_level, 0);
    // FIELDS=14 instance: count 15 is an error, count 14 is accepted
    v14 = 1'b1; b14 = 28'hABCDEF1; c14 = 4'hF;
    step();
    check("f14_err", cerr14, 1);
    check("f14_fill", fill14, 0);
    check("f14_frame", frm14, 0);
    check("f14_drop", drp14, 0);
    c14 = 4'hE;
    step();
    v14 = 1'b0;
    check("f14_acc_frame", frm14, 1);
    check("f14_acc_field", fld14, 14);
    check("f14_acc_data", rdd14, {4'hE, 28'hABCDEF1});
    // reset clears field_total, then count 14 accepted
    push({4'hF, 30'h55});
    do_reset();
    check("rst2_frame", frame_count, 0);
    check("rst2_field", field_total, 0);
    push({4'hE, 30'h77});
    check("c14_field", field_total, 14);
    check("c14_frame", frame_count, 1);
    step();
    // full FIFO with overflow
    do_reset();
    rd_ready = 1'b0;
    for (int k = 0; k < 17; k++) push(wd(k));
    check("full_fill", fill_level, 16);
    check("full_drop", drop_count, 1);
    check("full_ovf", overflow, 1);
    check("full_frame", frame_count, 16);
    check("full_head", rd_data, wd(0));
    dct_valid = 1'b1;
    {dct_count, dct_buffer} = wd(100);
    rd_ready = 1'b1;
    step();
    dct_valid = 1'b0;
    check("pushpop_fill", fill_level, 16);
    check("pushpop_frame", frame_count, 17);
    check("pushpop_drop", drop_count, 1);
    for (int k = 1; k < 16; k++) exp_q.push_back(wd(k));
    exp_q.push_back(wd(100));
    for (int i = 0; i < 16; i++) begin
      check($sformatf("readout_%0d", i), rd_data, exp_q[i]);
      step();
    end
    check("readout_empty", rd_valid, 0);
    // drain
    do_reset();
    rd_ready = 1'b0;
    for (int k = 0; k < 3; k++) push(wd(k));
    test_ending = 1'b1;
    step();
    test_ending = 1'b0;
    check("drain_state", state, 1);
    push(wd(5));
    push(wd(6));
    check("drain_drop", drop_count, 2);
    check("drain_fill", fill_level, 3);
    check("drain_ovf", overflow, 0);
    rd_ready = 1'b1;
    step();
    step();
    check("drain_state2", state, 1);
    check("drain_notdone", test_done, 0);
    step();
    rd_ready = 1'b0;
    check("drain_done_state", state, 2);
    check("drain_test_done", test_done, 1);
    check("drain_fill0", fill_level, 0);
    // hard end
    do_reset();
    for (int k = 0; k < 5; k++) push(wd(k));
    check("hard_pre_fill", fill_level, 5);
    test_ending = 1'b1;
    test_has_ended = 1'b1;
    step();
    test_ending = 1'b0;
    test_has_ended = 1'b0;
    check("hard_state", state, 2);
    check("hard_fill", fill_level, 0);
    check("hard_rd_valid", rd_valid, 0);
    check("hard_test_done", test_done, 1);
    // async reset mid-burst
    do_reset();
    for (int k = 0; k < 3; k++) push(wd(k + 1));
    dct_valid = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    check("async_fill", fill_level, 0);
    check("async_rd_valid", rd_valid, 0);
    check("async_rd_data", rd_data, 0);
    check("async_frame", frame_count, 0);
    check("async_field", field_total, 0);
    check("async_state", state, 0);
    dct_valid = 1'b0;
    reset_n = 1'b1;
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
